// File: rtl/tlp_pkg.sv
// Shared constants for the PCIe TX TLP engine: fmt/type codes, command field
// offsets, command type codes and the FSM state encoding.
package tlp_pkg;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [1:0] FMT_4DW_DATA   = 2'b11;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;

  localparam int unsigned CMD_W       = 84;
  localparam int unsigned CMD_TYPE_HI = 83;
  localparam int unsigned CMD_TYPE_LO = 82;
  localparam int unsigned CMD_LEN_HI  = 81;
  localparam int unsigned CMD_LEN_LO  = 72;
  localparam int unsigned CMD_ADDR_HI = 71;
  localparam int unsigned CMD_ADDR_LO = 8;
  localparam int unsigned CMD_TAG_HI  = 7;
  localparam int unsigned CMD_TAG_LO  = 0;

  localparam logic [1:0] CMD_MRD32 = 2'b00;
  localparam logic [1:0] CMD_MWR32 = 2'b01;
  localparam logic [1:0] CMD_MRD64 = 2'b10;
  localparam logic [1:0] CMD_MWR64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR0 = 2'd1,
    ST_HDR1 = 2'd2,
    ST_DATA = 2'd3
  } tx_state_t;

  // A length field of 0 encodes the 1024-DW maximum.
  function automatic logic [10:0] len_to_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/tlp_tx_hdr_build.sv
// Combinational TLP header builder: latched command + requester ID -> DW0..DW3.
// Optional TLP_TX_AUTO_3DW_EN sends 64-bit requests below 4 GB as 3DW TLPs.
module tlp_tx_hdr_build
  import tlp_pkg::*;
(
  input  logic [CMD_W-1:0] i_cmd,
  input  logic [15:0]      i_requester_id,
  output logic [31:0]      o_dw0,
  output logic [31:0]      o_dw1,
  output logic [31:0]      o_dw2,
  output logic [31:0]      o_dw3,
  output logic             o_is_4dw,
  output logic             o_is_write
);

  logic [1:0]  w_type;
  logic [9:0]  w_len;
  logic [63:0] w_addr;
  logic [7:0]  w_tag;
  logic [3:0]  w_last_be;

  assign w_type     = i_cmd[CMD_TYPE_HI:CMD_TYPE_LO];
  assign w_len      = i_cmd[CMD_LEN_HI:CMD_LEN_LO];
  assign w_addr     = i_cmd[CMD_ADDR_HI:CMD_ADDR_LO] & ~64'h3;
  assign w_tag      = i_cmd[CMD_TAG_HI:CMD_TAG_LO];
  assign o_is_write = w_type[0];

`ifdef TLP_TX_AUTO_3DW_EN
  assign o_is_4dw = w_type[1] && (w_addr[63:32] != 32'h0);
`else
  assign o_is_4dw = w_type[1];
`endif

  assign w_last_be = (w_len == 10'd1) ? 4'h0 : 4'hF;

  assign o_dw0 = {1'b0, o_is_write, o_is_4dw, TYPE_MEM, 8'h00, 6'b000000, w_len};
  assign o_dw1 = {i_requester_id, w_tag, w_last_be, 4'hF};
  assign o_dw2 = o_is_4dw ? w_addr[63:32] : w_addr[31:0];
  assign o_dw3 = w_addr[31:0];

endmodule

// File: rtl/tlp_tx_engine.sv
// PCIe TX TLP engine: pops memory commands, emits MRd/MWr TLPs on a 64-bit
// AXI4-Stream port, merging write payload. Optional macro: TLP_TX_AUTO_3DW_EN.
module tlp_tx_engine
  import tlp_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_CMD_WIDTH  = 84
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_CMD_WIDTH-1:0]    cmd_dout,
  input  logic                      cmd_empty,
  output logic                      cmd_rd_en,
  input  logic [C_DATA_WIDTH-1:0]   dat_dout,
  input  logic                      dat_empty,
  output logic                      dat_rd_en,
  input  logic [15:0]               requester_id,
  output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
  output logic [C_DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
  output logic                      s_axis_tx_tlast,
  output logic                      s_axis_tx_tvalid,
  input  logic                      s_axis_tx_tready,
  output logic                      busy
);

  tx_state_t r_state;
  tx_state_t w_next;

  logic [C_CMD_WIDTH-1:0] r_cmd;
  logic [15:0]            r_rid;
  logic [10:0]            r_rem;
  logic [31:0]            r_hold;

  logic [31:0] w_dw0, w_dw1, w_dw2, w_dw3;
  logic        w_is_4dw, w_is_write, w_hs;

  tlp_tx_hdr_build u_hdr (
    .i_cmd          (r_cmd),
    .i_requester_id (r_rid),
    .o_dw0          (w_dw0),
    .o_dw1          (w_dw1),
    .o_dw2          (w_dw2),
    .o_dw3          (w_dw3),
    .o_is_4dw       (w_is_4dw),
    .o_is_write     (w_is_write)
  );

  assign w_hs = s_axis_tx_tvalid && s_axis_tx_tready;
  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (!cmd_empty)       w_next = ST_HDR0;
      ST_HDR0: if (s_axis_tx_tready) w_next = ST_HDR1;
      ST_HDR1: if (w_hs)             w_next = s_axis_tx_tlast ? ST_IDLE : ST_DATA;
      ST_DATA: if (w_hs && s_axis_tx_tlast) w_next = ST_IDLE;
      default:                       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_rd_en        = 1'b0;
    dat_rd_en        = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    case (r_state)
      ST_IDLE: cmd_rd_en = !cmd_empty && !rst;
      ST_HDR0: begin
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tdata  = {w_dw1, w_dw0};
        s_axis_tx_tkeep  = 8'hFF;
      end
      ST_HDR1: begin
        if (w_is_4dw) begin
          s_axis_tx_tvalid = 1'b1;
          s_axis_tx_tdata  = {w_dw3, w_dw2};
          s_axis_tx_tkeep  = 8'hFF;
          s_axis_tx_tlast  = !w_is_write;
        end else if (!w_is_write) begin
          s_axis_tx_tvalid = 1'b1;
          s_axis_tx_tdata  = {32'h0, w_dw2};
          s_axis_tx_tkeep  = 8'h0F;
          s_axis_tx_tlast  = 1'b1;
        end else begin
          // 3DW write: first payload DW shares the beat with the address
          s_axis_tx_tvalid = !dat_empty;
          s_axis_tx_tdata  = {dat_dout[31:0], w_dw2};
          s_axis_tx_tkeep  = 8'hFF;
          s_axis_tx_tlast  = (r_rem == 11'd1);
          dat_rd_en        = !dat_empty && s_axis_tx_tready;
        end
      end
      ST_DATA: begin
        if (w_is_4dw) begin
          s_axis_tx_tvalid = !dat_empty;
          s_axis_tx_tdata  = dat_dout;
          s_axis_tx_tkeep  = (r_rem >= 11'd2) ? 8'hFF : 8'h0F;
          s_axis_tx_tlast  = (r_rem <= 11'd2);
          dat_rd_en        = !dat_empty && s_axis_tx_tready;
        end else if (r_rem >= 11'd2) begin
          s_axis_tx_tvalid = !dat_empty;
          s_axis_tx_tdata  = {dat_dout[31:0], r_hold};
          s_axis_tx_tkeep  = 8'hFF;
          s_axis_tx_tlast  = (r_rem == 11'd2);
          dat_rd_en        = !dat_empty && s_axis_tx_tready;
        end else begin
          s_axis_tx_tvalid = 1'b1;
          s_axis_tx_tdata  = {32'h0, r_hold};
          s_axis_tx_tkeep  = 8'h0F;
          s_axis_tx_tlast  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd  <= '0;
      r_rid  <= '0;
      r_rem  <= '0;
      r_hold <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (!cmd_empty) begin
          r_cmd <= cmd_dout;
          r_rid <= requester_id;
          r_rem <= len_to_dw(cmd_dout[CMD_LEN_HI:CMD_LEN_LO]);
        end
        ST_HDR1: if (dat_rd_en) begin
          r_hold <= dat_dout[63:32];
          r_rem  <= r_rem - 11'd1;
        end
        ST_DATA: if (w_hs) begin
          if (r_rem >= 11'd2) begin
            r_rem  <= r_rem - 11'd2;
            r_hold <= dat_dout[63:32];
          end else begin
            r_rem <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_tx_engine.sv
// Scoreboard bench for tlp_tx_engine: FIFO models feed commands/payload, an
// independent DW-stream model predicts every AXI-Stream beat.
module tb_tlp_tx_engine;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [83:0] cmd_dout;
  logic        cmd_empty;
  logic        cmd_rd_en;
  logic [63:0] dat_dout;
  logic        dat_empty;
  logic        dat_rd_en;
  logic [15:0] requester_id;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic        s_axis_tx_tready;
  logic        busy;

  beat_t       expq[$];
  logic [83:0] cmdq[$];
  logic [63:0] dq[$];

  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;
  int unsigned n_dpop = 0;
  logic        tr_rand  = 1'b0;
  logic        dat_hide = 1'b0;

  tlp_tx_engine #(.C_DATA_WIDTH(64), .C_CMD_WIDTH(84)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_dout         (cmd_dout),
    .cmd_empty        (cmd_empty),
    .cmd_rd_en        (cmd_rd_en),
    .dat_dout         (dat_dout),
    .dat_empty        (dat_empty),
    .dat_rd_en        (dat_rd_en),
    .requester_id     (requester_id),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO models and tready: pop on the sampled rd_en, refresh FWFT outputs.
  initial begin
    logic pc, pd;
    cmd_empty = 1'b1; cmd_dout = '0; dat_empty = 1'b1; dat_dout = '0;
    s_axis_tx_tready = 1'b1;
    forever begin
      @(negedge clk);
      pc = cmd_rd_en;
      pd = dat_rd_en;
      @(posedge clk);
      #1;
      if (pc && cmdq.size() != 0) void'(cmdq.pop_front());
      if (pd && dq.size() != 0) begin
        void'(dq.pop_front());
        n_dpop++;
      end
      cmd_empty = (cmdq.size() == 0);
      cmd_dout  = (cmdq.size() != 0) ? cmdq[0] : '0;
      dat_empty = (dq.size() == 0) || dat_hide;
      dat_dout  = (dq.size() != 0) ? dq[0] : '0;
      s_axis_tx_tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (s_axis_tx_tvalid) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          check("tdata", s_axis_tx_tdata, expq[0].d);
          check("tkeep", {56'h0, s_axis_tx_tkeep}, {56'h0, expq[0].k});
          check("tlast", {63'h0, s_axis_tx_tlast}, {63'h0, expq[0].l});
          if (s_axis_tx_tready) void'(expq.pop_front());
        end
      end
      if (dat_rd_en)
        check("dat_pop_ok", {63'h0, !dat_empty && s_axis_tx_tvalid && s_axis_tx_tready}, 64'd1);
      if (cmd_rd_en)
        check("cmd_pop_ok", {63'h0, !cmd_empty && !busy}, 64'd1);
    end
  end

  task automatic send(input logic [1:0] t, input logic [9:0] len,
                      input logic [63:0] addr, input logic [7:0] tag);
    logic [31:0]  dws[$];
    logic [63:0]  words[$];
    logic [63:0]  w, lw, a;
    logic         is_w, is4;
    int unsigned  n;
    beat_t        b;
    n    = (len == 10'd0) ? 1024 : int'(len);
    is_w = t[0];
`ifdef TLP_TX_AUTO_3DW_EN
    is4  = t[1] && (addr[63:32] != 32'h0);
`else
    is4  = t[1];
`endif
    a = {addr[63:2], 2'b00};
    dws.push_back({1'b0, is_w, is4, 5'b00000, 14'h0, len});
    dws.push_back({requester_id, tag, (n == 1) ? 4'h0 : 4'hF, 4'hF});
    if (is4) begin
      dws.push_back(a[63:32]);
      dws.push_back(a[31:0]);
    end else begin
      dws.push_back(a[31:0]);
    end
    if (is_w) begin
      for (int unsigned i = 0; i < (n + 1) / 2; i++) begin
        w = {$urandom, $urandom};
        dq.push_back(w);
        words.push_back(w);
      end
      for (int unsigned i = 0; i < n; i++) begin
        lw = words[i / 2];
        dws.push_back((i % 2) ? lw[63:32] : lw[31:0]);
      end
    end
    for (int unsigned i = 0; i < dws.size(); i += 2) begin
      if (i + 1 < dws.size()) begin
        b.d = {dws[i + 1], dws[i]};
        b.k = 8'hFF;
        b.l = (i + 2 == dws.size());
      end else begin
        lw  = (words.size() != 0) ? words[words.size() - 1] : '0;
        b.d = {(is4 && is_w) ? lw[63:32] : 32'h0, dws[i]};
        b.k = 8'h0F;
        b.l = 1'b1;
      end
      expq.push_back(b);
    end
    cmdq.push_back({t, len, addr, tag});
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while ((expq.size() != 0 || cmdq.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_timeout"}, {63'h0, n < budget}, 64'd1);
    check({tag, "_dq_left"}, 64'(dq.size()), 64'd0);
    check({tag, "_busy"}, {63'h0, busy}, 64'd0);
  endtask

  initial begin
    int unsigned base, n;
    rst = 1'b1;
    requester_id = 16'h0100;
    send(2'b00, 10'd1, 64'h0000_0000_1000_0004, 8'h05);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {63'h0, s_axis_tx_tvalid}, 64'd0);
    check("rst_tdata", s_axis_tx_tdata, 64'd0);
    check("rst_tkeep", {56'h0, s_axis_tx_tkeep}, 64'd0);
    check("rst_tlast", {63'h0, s_axis_tx_tlast}, 64'd0);
    check("rst_cmd_rd_en", {63'h0, cmd_rd_en}, 64'd0);
    check("rst_dat_rd_en", {63'h0, dat_rd_en}, 64'd0);
    check("rst_busy", {63'h0, busy}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    base = n_dpop;
    drain("mrd32", 100);
    check("mrd32_pops", 64'(n_dpop - base), 64'd0);

    base = n_dpop;
    send(2'b01, 10'd3, 64'h0000_0000_2000_0010, 8'h11);
    drain("mwr32_len3", 100);
    check("mwr32_len3_pops", 64'(n_dpop - base), 64'd2);

    send(2'b11, 10'd4, 64'h0000_0001_2345_6780, 8'h22);
    drain("mwr64_len4", 100);

    base = n_dpop;
    tr_rand  = 1'b1;
    dat_hide = 1'b1;
    send(2'b01, 10'd2, 64'h0000_0000_3000_0008, 8'h33);
    repeat (4) begin @(posedge clk); #2; end
    dat_hide = 1'b0;
    drain("stall_len2", 200);
    check("stall_len2_pops", 64'(n_dpop - base), 64'd1);
    tr_rand = 1'b0;

    send(2'b10, 10'd0, 64'h0000_00AB_0000_0103, 8'h44);
    drain("mrd64_len0", 100);

    base = n_dpop;
    send(2'b11, 10'd0, 64'h0000_0002_0000_0000, 8'h55);
    drain("mwr64_len1024", 2000);
    check("mwr64_len1024_pops", 64'(n_dpop - base), 64'd512);

    requester_id = 16'hBEEF;
    tr_rand = 1'b1;
    send(2'b11, 10'd3, 64'h0000_0003_0000_0047, 8'h66);
    send(2'b01, 10'd1, 64'h0000_0000_4000_0002, 8'h77);
    send(2'b10, 10'd2, 64'h0000_0004_0000_0000, 8'h88);
    drain("b2b", 300);
    tr_rand = 1'b0;

    send(2'b11, 10'd2, 64'h0000_0000_8000_0000, 8'h99);
    drain("mwr64_low", 100);

    base = n_dpop;
    send(2'b01, 10'd8, 64'h0000_0000_5000_0000, 8'hAA);
    n = 0;
    while (n_dpop < base + 2 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("rst_mid_wait", {63'h0, n < 200}, 64'd1);
    check("rst_mid_busy_before", {63'h0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_tvalid", {63'h0, s_axis_tx_tvalid}, 64'd0);
    check("rst_mid_busy", {63'h0, busy}, 64'd0);
    check("rst_mid_dat_rd_en", {63'h0, dat_rd_en}, 64'd0);
    expq.delete();
    cmdq.delete();
    dq.delete();
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    @(posedge clk); #2;
    send(2'b01, 10'd2, 64'h0000_0000_6000_0004, 8'hBB);
    drain("after_rst", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
